// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem: AXI4-Lite slave in front of a DEPTH x DATA_WIDTH word array.
// Host-side control/data window of the CNN accelerator. It allows one write and
// one read outstanding at a time, and the two paths run independently.
// Optional build macro AXIL_ADDR_DECERR_EN: when defined, an address outside the
// array returns DECERR (2'b11). In that case writes are dropped and reads return 0.
// When undefined, the upper address bits alias modulo DEPTH.
module axi_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic                    i_bready,
    output logic                    o_bvalid,
    output logic [1:0]              o_bresp,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_rvalid,
    output logic [1:0]              o_rresp
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = OFF_W + IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  aw_held, w_held, aw_err;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;

    logic aw_hs, w_hs, ar_hs, commit;
    logic aw_err_in, ar_err_in;
    logic aw_held_n, w_held_n, bvalid_n, rvalid_n;

    assign aw_hs  = i_awvalid & o_awready;
    assign w_hs   = i_wvalid  & o_wready;
    assign ar_hs  = i_arvalid & o_arready;
    // The commit fires one cycle after both halves of the write are held.
    assign commit = aw_held & w_held;

`ifdef AXIL_ADDR_DECERR_EN
    assign aw_err_in = |i_awaddr[ADDR_WIDTH-1:HI_LSB];
    assign ar_err_in = |i_araddr[ADDR_WIDTH-1:HI_LSB];
    logic unused_addr;
    assign unused_addr = &{1'b0, i_awaddr[OFF_W-1:0], i_araddr[OFF_W-1:0]};
`else
    assign aw_err_in = 1'b0;
    assign ar_err_in = 1'b0;
    logic unused_addr;
    assign unused_addr = &{1'b0, i_awaddr[OFF_W-1:0], i_araddr[OFF_W-1:0],
                           i_awaddr[ADDR_WIDTH-1:HI_LSB], i_araddr[ADDR_WIDTH-1:HI_LSB]};
`endif

    // Next-state of the capture flags and valids. The ready outputs are
    // derived from these so that they are registered.
    always_comb begin
        aw_held_n = (aw_held | aw_hs) & ~commit;
        w_held_n  = (w_held  | w_hs)  & ~commit;
        bvalid_n  = commit | (o_bvalid & ~i_bready);
        rvalid_n  = ar_hs  | (o_rvalid & ~i_rready);
    end

    // Write channel: capture AW and W independently, then raise B after the commit.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx    <= '0;
            aw_err    <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
            o_bresp   <= 2'b00;
        end else begin
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            o_bvalid  <= bvalid_n;
            o_awready <= ~aw_held_n & ~bvalid_n;
            o_wready  <= ~w_held_n  & ~bvalid_n;
            if (aw_hs) begin
                aw_idx <= i_awaddr[OFF_W +: IDX_W];
                aw_err <= aw_err_in;
            end
            if (w_hs) begin
                w_data <= i_wdata;
                w_strb <= i_wstrb;
            end
            if (commit)
                o_bresp <= aw_err ? 2'b11 : 2'b00;
        end
    end

    // Byte-strobed array write. Reset clears the capture flags, which blocks a partial commit.
    always_ff @(posedge i_aclk) begin
        if (commit && !aw_err) begin
            for (int b = 0; b < STRB_W; b++)
                if (w_strb[b])
                    mem[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
        end
    end

    // Read channel: on AR, register the word, then hold it until R is accepted.
    // This samples the array in the same edge as a write, so a colliding read sees the old data.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_arready <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rdata   <= '0;
            o_rresp   <= 2'b00;
        end else begin
            o_rvalid  <= rvalid_n;
            o_arready <= ~rvalid_n;
            if (ar_hs) begin
                o_rdata <= ar_err_in ? '0 : mem[i_araddr[OFF_W +: IDX_W]];
                o_rresp <= ar_err_in ? 2'b11 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem (DATA_WIDTH=32, DEPTH=256).
// The expected values follow whether AXIL_ADDR_DECERR_EN is defined.
module tb_axi_lite_slave_mem;
    logic        i_aclk, i_areset;
    logic [31:0] i_awaddr, i_wdata, i_araddr;
    logic [3:0]  i_wstrb;
    logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;

    axi_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256)) dut (
        .i_aclk(i_aclk), .i_areset(i_areset),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .i_bready(i_bready), .o_bvalid(o_bvalid), .o_bresp(o_bresp),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .i_rready(i_rready), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rresp(o_rresp)
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_aclk);
        #1;
    endtask

    // Full write. hold = number of cycles to keep bready low after bvalid.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, output logic [1:0] resp);
        int   n;
        logic aw_go, w_go;
        n = 0;
        i_awaddr = a; i_awvalid = 1'b1;
        i_wdata = d; i_wstrb = s; i_wvalid = 1'b1;
        i_bready = (hold == 0);
        while ((i_awvalid || i_wvalid) && n < 50) begin
            aw_go = i_awvalid & o_awready;
            w_go  = i_wvalid & o_wready;
            step();
            if (aw_go) i_awvalid = 1'b0;
            if (w_go)  i_wvalid  = 1'b0;
            n++;
        end
        while (!o_bvalid && n < 50) begin
            step();
            n++;
        end
        chk("wr_done", n < 50, 1);
        resp = o_bresp;
        for (int k = 0; k < hold; k++) begin
            step();
            chk("b_hold_vld", o_bvalid, 1);
            chk("b_hold_resp", o_bresp, resp);
            chk("b_hold_awrdy", o_awready, 0);
            chk("b_hold_wrdy", o_wready, 0);
        end
        i_bready = 1'b1;
        step();
        chk("b_clear", o_bvalid, 0);
        chk("b_awrdy_back", o_awready, 1);
        i_bready = 1'b0; i_awvalid = 1'b0; i_wvalid = 1'b0;
    endtask

    // Full read. hold = number of cycles to keep rready low after rvalid.
    task automatic axi_rd(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp);
        int   n;
        logic go;
        n = 0;
        i_araddr = a; i_arvalid = 1'b1;
        i_rready = (hold == 0);
        while (i_arvalid && n < 50) begin
            go = o_arready;
            step();
            if (go) i_arvalid = 1'b0;
            n++;
        end
        while (!o_rvalid && n < 50) begin
            step();
            n++;
        end
        chk("rd_done", n < 50, 1);
        d = o_rdata; resp = o_rresp;
        for (int k = 0; k < hold; k++) begin
            step();
            chk("r_hold_vld", o_rvalid, 1);
            chk("r_hold_data", o_rdata, d);
            chk("r_hold_arrdy", o_arready, 0);
        end
        i_rready = 1'b1;
        step();
        chk("r_clear", o_rvalid, 0);
        chk("r_arrdy_back", o_arready, 1);
        i_rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        i_areset = 1'b1;
        i_awaddr = '0; i_awvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wvalid = 1'b0;
        i_bready = 1'b0; i_araddr = '0; i_arvalid = 1'b0; i_rready = 1'b0;
        step(); step();
        chk("rst_awready", o_awready, 0);
        chk("rst_wready", o_wready, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_bresp", o_bresp, 0);
        chk("rst_arready", o_arready, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rresp", o_rresp, 0);
        i_areset = 1'b0;
        step();
        chk("idle_awready", o_awready, 1);
        chk("idle_wready", o_wready, 1);
        chk("idle_arready", o_arready, 1);

        // Basic write/read
        axi_wr(32'h0, 32'hDEADBEEF, 4'hF, 0, resp);
        chk("w0_resp", resp, 2'b00);
        axi_rd(32'h0, 0, rd, resp);
        chk("r0_data", rd, 32'hDEADBEEF);
        chk("r0_resp", resp, 2'b00);

        axi_wr(32'h4, 32'hCAFEBABE, 4'hF, 0, resp);
        axi_rd(32'h4, 0, rd, resp);
        chk("r4_data", rd, 32'hCAFEBABE);
        axi_rd(32'h0, 0, rd, resp);
        chk("r0_again", rd, 32'hDEADBEEF);

        // W three cycles ahead of AW
        i_wdata = 32'h11223344; i_wstrb = 4'hF; i_wvalid = 1'b1; i_bready = 1'b1;
        chk("wfirst_wrdy", o_wready, 1);
        step();
        i_wvalid = 1'b0;
        chk("wfirst_wrdy_drop", o_wready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wfirst_no_b", o_bvalid, 0);
        end
        i_awaddr = 32'h8; i_awvalid = 1'b1;
        chk("wfirst_awrdy", o_awready, 1);
        step();
        i_awvalid = 1'b0;
        chk("wfirst_b_wait", o_bvalid, 0);
        step();
        chk("wfirst_b_up", o_bvalid, 1);
        chk("wfirst_bresp", o_bresp, 2'b00);
        step();
        chk("wfirst_b_done", o_bvalid, 0);
        chk("wfirst_awrdy_back", o_awready, 1);
        i_bready = 1'b0;
        axi_rd(32'h8, 0, rd, resp);
        chk("r8_data", rd, 32'h11223344);

        // Partial strobes
        axi_wr(32'h0, 32'hAABBCCDD, 4'b0101, 0, resp);
        axi_rd(32'h0, 0, rd, resp);
        chk("strb_data", rd, 32'hDEBBBEDD);

        // Back-pressure on B and R
        axi_wr(32'hC, 32'h55667788, 4'hF, 5, resp);
        chk("bp_bresp", resp, 2'b00);
        axi_rd(32'hC, 5, rd, resp);
        chk("bp_rdata", rd, 32'h55667788);

        // Zero strobes leave the memory unchanged
        axi_wr(32'h4, 32'hFFFFFFFF, 4'h0, 0, resp);
        chk("strb0_resp", resp, 2'b00);
        axi_rd(32'h4, 0, rd, resp);
        chk("strb0_data", rd, 32'hCAFEBABE);

        // Out-of-range address
        axi_wr(32'h400, 32'h12345678, 4'hF, 0, resp);
`ifdef AXIL_ADDR_DECERR_EN
        chk("oor_bresp", resp, 2'b11);
        axi_rd(32'h400, 0, rd, resp);
        chk("oor_rdata", rd, 0);
        chk("oor_rresp", resp, 2'b11);
        axi_rd(32'h0, 0, rd, resp);
        chk("oor_word0", rd, 32'hDEBBBEDD);
`else
        chk("alias_bresp", resp, 2'b00);
        axi_rd(32'h400, 0, rd, resp);
        chk("alias_rdata", rd, 32'h12345678);
        chk("alias_rresp", resp, 2'b00);
        axi_rd(32'h0, 0, rd, resp);
        chk("alias_word0", rd, 32'h12345678);
`endif

        // Reset between capture and commit aborts the write
        axi_wr(32'h10, 32'h0BADF00D, 4'hF, 0, resp);
        i_awaddr = 32'h10; i_wdata = 32'hFFFFFFFF; i_wstrb = 4'hF;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b1;
        step();
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        i_areset = 1'b1;
        #1;
        chk("abort_awready", o_awready, 0);
        chk("abort_wready", o_wready, 0);
        step();
        i_areset = 1'b0;
        step(); step();
        chk("abort_no_b", o_bvalid, 0);
        i_bready = 1'b0;
        axi_rd(32'h10, 0, rd, resp);
        chk("abort_data", rd, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
